// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-filtered, strictly in-order release of NUM_STAGES reset domains.
// Define RST_SEQ_TIMEOUT_EN to compile in the stage_done timeout and FAULT state.
module reset_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_DELAY  = 256,
    parameter int LOCK_FILTER  = 16,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic                  sys_aclk,
    input  logic                  sys_areset,
    input  logic                  mmcm_locked,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_aresetn,
    output logic                  all_ready,
    output logic                  timeout_err,
    output logic [2:0]            err_stage,
    output logic [2:0]            seq_state
);
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RELEASE   = 3'd2,
        SETTLE    = 3'd3,
        WAIT_DONE = 3'd4,
        READY     = 3'd5,
        FAULT     = 3'd6
    } state_e;

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_DELAY < 1 || STAGE_DELAY > 65535 ||
        LOCK_FILTER < 1 || LOCK_FILTER > 255 || DONE_TIMEOUT < 1 || DONE_TIMEOUT > 65535) begin : g_bad_param
        $error("reset_sequencer: parameter out of range");
    end

    localparam logic [15:0] FILTER_LAST = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(STAGE_DELAY - 1);
    localparam logic [2:0]  IDX_LAST    = 3'(NUM_STAGES - 1);

    logic                  lock_s1_q, lock_q;
    logic [NUM_STAGES-1:0] done_s1_q, done_q;
    state_e                state_q;
    logic [2:0]            idx_q;
    logic [15:0]           cnt_q, cnt_inc;
    logic [NUM_STAGES-1:0] rstn_q, sel;
    logic                  ready_q, done_hit, abort, to_hit;

    always_ff @(posedge sys_aclk) begin
        if (sys_areset) begin
            lock_s1_q <= 1'b0;
            lock_q    <= 1'b0;
            done_s1_q <= '0;
            done_q    <= '0;
        end else begin
            lock_s1_q <= mmcm_locked;
            lock_q    <= lock_s1_q;
            done_s1_q <= stage_done;
            done_q    <= done_s1_q;
        end
    end

    assign sel      = NUM_STAGES'(1) << idx_q;
    assign done_hit = |(done_q & sel);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    // Lock loss in WAIT_LOCK is already the idle condition, so treating it as abort there is harmless.
    assign abort    = sw_rst_req || !lock_q;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);
    logic       terr_q;
    logic [2:0] err_stage_q;
    assign to_hit = !abort && state_q == WAIT_DONE && !done_hit && cnt_q == TIMEOUT_LAST;
    always_ff @(posedge sys_aclk) begin
        if (sys_areset) begin
            terr_q      <= 1'b0;
            err_stage_q <= '0;
        end else if (to_hit) begin
            terr_q      <= 1'b1;
            err_stage_q <= idx_q;
        end
    end
    assign timeout_err = terr_q;
    assign err_stage   = err_stage_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
    assign err_stage   = 3'd0;
`endif

    always_ff @(posedge sys_aclk) begin
        if (sys_areset || abort) begin
            state_q <= WAIT_LOCK;
            idx_q   <= '0;
            cnt_q   <= '0;
            rstn_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_q <= FILTER;
                    cnt_q   <= '0;
                end
                FILTER: begin
                    state_q <= (cnt_q == FILTER_LAST) ? RELEASE : FILTER;
                    cnt_q   <= (cnt_q == FILTER_LAST) ? 16'd0 : cnt_inc;
                end
                RELEASE: begin
                    rstn_q  <= rstn_q | sel;
                    state_q <= SETTLE;
                    cnt_q   <= '0;
                end
                SETTLE: begin
                    state_q <= (cnt_q == SETTLE_LAST) ? WAIT_DONE : SETTLE;
                    cnt_q   <= (cnt_q == SETTLE_LAST) ? 16'd0 : cnt_inc;
                end
                WAIT_DONE: begin
                    if (done_hit) begin
                        cnt_q   <= '0;
                        state_q <= (idx_q == IDX_LAST) ? READY : RELEASE;
                        ready_q <= (idx_q == IDX_LAST);
                        idx_q   <= (idx_q == IDX_LAST) ? idx_q : idx_q + 3'd1;
                    end else if (to_hit) begin
                        cnt_q   <= '0;
                        state_q <= FAULT;
                        rstn_q  <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                READY: ready_q <= 1'b1;
                default: rstn_q <= '0;
            endcase
        end
    end

    assign stage_aresetn = rstn_q;
    assign all_ready     = ready_q;
    assign seq_state     = state_q;
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_STAGES, 4, number of sequenced downstream reset domains (1..8).
- STAGE_DELAY, 256, cycles a stage stays released before its done is sampled (1..65535).
- LOCK_FILTER, 16, consecutive cycles mmcm_locked must be high before sequencing starts (1..255).
- DONE_TIMEOUT, 65535, max cycles to wait for a stage's done (1..65535).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- sys_aclk, in, 1, sole clock (100 MHz system clock).
- sys_areset, in, 1, reset; synchronous, active-high.
- mmcm_locked, in, 1, clock-generator lock, asynchronous to sys_aclk.
- stage_done, in, NUM_STAGES, per-stage ready (e.g. calib/link-up), asynchronous.
- sw_rst_req, in, 1, single-cycle request to restart the full sequence.
- stage_aresetn, out, NUM_STAGES, per-stage active-low reset, registered.
- all_ready, out, 1, high when every stage is released and done.
- timeout_err, out, 1, sticky timeout flag.
- err_stage, out, 3, index of the stage that timed out.
- seq_state, out, 3, current FSM state encoding.

Function
REQ-003 mmcm_locked and each stage_done bit SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized versions.

REQ-004 The FSM states SHALL be encoded as WAIT_LOCK=0, FILTER=1, RELEASE=2, SETTLE=3, WAIT_DONE=4, READY=5, FAULT=6.

REQ-005 State transitions SHALL be:
- WAIT_LOCK -> FILTER on synced lock = 1.
- FILTER -> RELEASE after LOCK_FILTER consecutive lock-high cycles; a lock drop returns to WAIT_LOCK and clears the filter counter.

REQ-006 RELEASE SHALL last one cycle and set stage_aresetn[idx] = 1, then go to SETTLE; idx starts at 0.

REQ-007 SETTLE SHALL count STAGE_DELAY cycles, then go to WAIT_DONE.

REQ-008 WAIT_DONE SHALL behave as follows:
- On synced stage_done[idx] = 1: if idx = NUM_STAGES-1, go to READY; otherwise increment idx and go to RELEASE.
- Released stages SHALL stay released; stages are released strictly in ascending index order.

REQ-009 READY SHALL hold all_ready = 1; all_ready SHALL be 0 in every other state.

REQ-010 Synced lock = 0 in any state other than WAIT_LOCK SHALL, on the next edge:
- drive all stage_aresetn to 0 and clear idx and all counters;
- go to WAIT_LOCK.

REQ-011 sw_rst_req = 1 in any state SHALL have the same effect as lock loss; if it coincides with lock loss, the result is identical (WAIT_LOCK).

REQ-012 A stage_done that deasserts after its stage completed SHALL be ignored.

REQ-013 Counter widths SHALL be 16 bits, with no wrap-around: counters saturate and are cleared on every state entry.

REQ-014 Output latency SHALL be:
- stage_aresetn changes exactly one cycle after the FSM decision;
- end-to-end from a stage_done pin edge to the next stage's release SHALL be 4 cycles (2 sync + 1 WAIT_DONE + 1 RELEASE).

Reset
REQ-015 With sys_areset = 1 at a rising edge, the block SHALL set:
- stage_aresetn = 0, all_ready = 0, timeout_err = 0, err_stage = 0;
- seq_state = WAIT_LOCK;
- idx, all counters and synchronizer flops = 0.

REQ-016 sys_areset asserted mid-sequence SHALL override every other input in that cycle.

REQ-017 timeout_err SHALL be cleared only by sys_areset, not by lock loss or sw_rst_req.

Configuration
REQ-018 When RST_SEQ_TIMEOUT_EN is defined, the timeout logic SHALL be compiled in:
- WAIT_DONE counts cycles; on reaching DONE_TIMEOUT without done, go to FAULT and set timeout_err = 1, err_stage = idx.
- FAULT holds all stage_aresetn = 0 and exits only via sys_areset, sw_rst_req or lock loss (-> WAIT_LOCK).

REQ-019 When RST_SEQ_TIMEOUT_EN is not defined:
- WAIT_DONE waits indefinitely;
- FAULT is unreachable;
- timeout_err and err_stage are tied to 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release, lock high at cycle 10, all done tied 1 -> stage 0 releases at cycle 10+2+16+1; each next stage follows STAGE_DELAY+2 cycles later; all_ready = 1 after stage 3's done is sampled.
- Lock pulses low for 1 cycle during FILTER at count 8 -> filter restarts; no stage released before a full 16 clean cycles.
- Lock drops while in SETTLE of stage 2 -> stage_aresetn = 4'b0000 next cycle, seq_state = 0, all_ready = 0; re-lock restarts from stage 0.
- sw_rst_req pulse in READY -> all resets assert, full sequence replays; timeout_err unchanged.
- With RST_SEQ_TIMEOUT_EN and DONE_TIMEOUT = 100, stage_done[1] held 0 -> FAULT after 100 WAIT_DONE cycles, timeout_err = 1, err_stage = 1, stages 0..3 = 0.
- Without RST_SEQ_TIMEOUT_EN, same stimulus for 10000 cycles -> remains in WAIT_DONE, timeout_err = 0; stage_done[1] = 1 -> sequence continues.
